uart_rx: RTL
============

Name: uart_rx

Overview:
- Receiver for the 9N1 serial link: 9 data bits, no parity, 1 stop bit, LSB first, idle-high line.
- Sits directly downstream of uart_tx and consumes its tx line.
- Synchronises the asynchronous line and samples each bit at its midpoint.
- Presents each received 9-bit word with a one-cycle valid pulse and flags frames whose stop bit is bad.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period; same value as uart_tx; minimum 4.

Ports:
- clock  input  1  system clock; all logic on the rising edge
- reset_n  input  1  synchronous, active-low reset
- rx  input  1  serial line, asynchronous to clock, idle high
- data  output  9  last good received word; bit 0 is the first data bit on the line
- valid  output  1  one-cycle pulse; data is new this cycle
- framing_error  output  1  one-cycle pulse; stop bit sampled low, frame discarded
- busy  output  1  high while a frame is being received (any state other than IDLE)

Behaviour:
- Reset (reset_n low at a clock edge):
  - data=0, valid=0, framing_error=0, busy=0.
  - State to IDLE; bit and cycle counters cleared.
  - Both synchroniser flops and the edge-detect register clear to 0.
  - Reset wins over every other event, including mid-frame.
- Synchroniser: 2 flops; rx_s is the second flop. All decisions use rx_s; raw rx is never used.
- Start detect: rx_s=0 while the previous rx_s=1, in IDLE. Because the sync flops reset to 0, a line held low through reset is never a start. The line must go high, then fall.
- State machine: IDLE, START, DATA, STOP.
- IDLE:
  - On a start edge go to START with cycle counter=0.
  - busy rises in the same cycle as the transition.
- START:
  - Counter increments each cycle. At count = (CLKS_PER_BIT-1)/2 (integer division), sample rx_s.
  - rx_s=1: false start; return to IDLE with no valid and no error.
  - rx_s=0: clear the counter, bit index=0, go to DATA.
- DATA:
  - Sample rx_s when the counter reaches CLKS_PER_BIT-1, then clear the counter.
  - Store each sample into shift register bit [bit index], LSB first.
  - After the sample with bit index=8, go to STOP; otherwise increment the bit index.
- STOP:
  - Sample rx_s at counter = CLKS_PER_BIT-1.
  - rx_s=1: data <= shift register and valid=1 in the next cycle.
  - rx_s=0: framing_error=1 in the next cycle and data is unchanged.
  - Either way go to IDLE; busy falls in the same cycle as the pulse.
- Line still low after a framing error (break): no new frame starts until rx_s goes high and then falls.
- Return to IDLE happens at the stop-bit midpoint, so a following start edge is accepted half a bit early. Back-to-back frames with no idle gap must be received.
- data holds its value until the next good frame. There is no handshake and no overrun detection; the consumer must take data on valid.
- valid and framing_error are never high in the same cycle.
- Latency:
  - Stop sample occurs 2 + 1 + (CLKS_PER_BIT-1)/2 + 10*CLKS_PER_BIT cycles after rx's first low cycle (±1 for asynchronous phase).
  - The valid pulse follows one cycle later.

Test Plan:
- Frame 9'h155 (9'b1_0101_0101), LSB first, CLKS_PER_BIT=434, driven by uart_tx or a bench model -> exactly one valid pulse 4561±2 cycles after the start edge; data=9'h155; framing_error never high; busy low afterwards.
- Back-to-back frames 9'h000 then 9'h1FF, no idle between stop and next start -> two valid pulses with data 9'h000 then 9'h1FF, no errors.
- Glitch: rx low for 100 cycles, then high -> busy pulses; no valid and no framing_error; the next legal frame 9'h0A5 is received correctly.
- Stop bit driven low on frame 9'h0AA with data previously 9'h155 -> one framing_error pulse, no valid, data stays 9'h155. With rx then held low 3*434 cycles, busy stays low until rx rises and a new start occurs.
- reset_n low for 1 cycle during data bit 4 of a frame -> next cycle data=0, valid=0, busy=0. A following full frame 9'h123 (sent after the line idles high) gives valid with data=9'h123.
- rx held low through reset release for 1000 cycles, then high, then frame 9'h1C3 -> no activity while low; a single valid pulse with data=9'h1C3.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 9N1 serial receiver (9 data bits LSB first, no parity, 1 stop bit,
// idle-high line). The asynchronous line is synchronised through two flops,
// a start is a falling edge seen while idle, and every bit is sampled at its
// midpoint.
//
// Ports:
//   clock          system clock, rising edge
//   reset_n        synchronous active-low reset
//   rx             serial line, asynchronous, idle high
//   data[8:0]      last good received word (bit 0 = first bit on the line)
//   valid          one-cycle pulse, data is new this cycle
//   framing_error  one-cycle pulse, stop bit sampled low, frame discarded
//   busy           high while a frame is being received
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [8:0] data,
  output logic       valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned NBITS = 9;
  localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW    = 4;
  localparam logic [CW-1:0] HALF_C = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX_C = IW'(NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic             rx_s;

  assign rx_s          = sync2_q;
  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = ferr_q;
  assign busy          = busy_q;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    case (state_q)
      S_IDLE: begin
        // Sync flops reset low, so a line held low through reset never
        // looks like a start: it must rise and then fall.
        if (!rx_s && prev_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_C) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == LAST_C) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == LAST_IDX_C) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        // Leaving at the stop midpoint lets a back-to-back start be caught.
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule
